// File: rtl/dphy_lane_tx_if.sv
// Word-stream in / per-lane HS byte out bundle for the D-PHY lane transmitter.
interface dphy_lane_tx_if #(
  parameter int unsigned DATA_LANES = 4
) ();
  logic [DATA_LANES-1:0][7:0] word_i;
  logic                       valid_i;
  logic                       eop_i;
  logic                       ready_o;
  logic                       hs_req_o;
  logic [DATA_LANES-1:0][7:0] byte_data_o;
  logic [DATA_LANES-1:0]      valid_o;
  logic                       underflow_o;

  modport master (
    output word_i, valid_i, eop_i,
    input  ready_o, hs_req_o, byte_data_o, valid_o, underflow_o
  );

  modport slave (
    input  word_i, valid_i, eop_i,
    output ready_o, hs_req_o, byte_data_o, valid_o, underflow_o
  );
endinterface

// File: rtl/dphy_lane_tx.sv
// D-PHY HS lane transmitter: wraps a word stream in PREP gap, per-lane SoT sync byte,
// payload and per-lane trailer, driving all lanes in lockstep.
module dphy_lane_tx #(
  parameter int unsigned DATA_LANES   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned PREP_CYCLES  = 2,
  parameter int unsigned TRAIL_CYCLES = 2
) (
  input logic          byte_clk_i,
  input logic          rst_n_i,
  dphy_lane_tx_if.slave bus
);

  localparam int unsigned MAX_CYC = (PREP_CYCLES > TRAIL_CYCLES) ? PREP_CYCLES : TRAIL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  // IDLE already spends one wire cycle in the prepare gap, so PREP holds one cycle less.
  localparam int unsigned PREP_LOAD  = (PREP_CYCLES > 1) ? PREP_CYCLES - 2 : 0;
  localparam int unsigned TRAIL_LOAD = (TRAIL_CYCLES > 0) ? TRAIL_CYCLES - 1 : 0;
  // Underflow emits the first trailer byte on the same edge it is detected.
  localparam int unsigned UF_LOAD    = (TRAIL_CYCLES > 1) ? TRAIL_CYCLES - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_SYNC,
    S_DATA,
    S_TRAIL,
    S_EXIT
  } state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [DATA_LANES-1:0]      last_msb;
  logic                       hs_req_q;
  logic [DATA_LANES-1:0][7:0] byte_data_q;
  logic [DATA_LANES-1:0]      valid_q;
  logic                       underflow_q;
  logic [DATA_LANES-1:0][7:0] trailer;

  // Trailer is the inverse of the last bit on the wire (bit 7, serialised LSB first).
  always_comb begin
    trailer = '0;
    for (int unsigned i = 0; i < DATA_LANES; i++) begin
      trailer[i] = {8{~last_msb[i]}};
    end
  end

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_msb    <= '0;
      hs_req_q    <= 1'b0;
      byte_data_q <= '0;
      valid_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.valid_i) begin
            hs_req_q <= 1'b1;
            if (PREP_CYCLES > 1) begin
              state <= S_PREP;
              cnt   <= CNT_W'(PREP_LOAD);
            end else begin
              state <= S_SYNC;
            end
          end
        end
        S_PREP: begin
          if (cnt == '0) state <= S_SYNC;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_SYNC: begin
          byte_data_q <= {DATA_LANES{SYNC_BYTE}};
          valid_q     <= '1;
          last_msb    <= {DATA_LANES{SYNC_BYTE[7]}};
          state       <= S_DATA;
        end
        S_DATA: begin
          if (bus.valid_i) begin
            byte_data_q <= bus.word_i;
            valid_q     <= '1;
            for (int unsigned i = 0; i < DATA_LANES; i++) begin
              last_msb[i] <= bus.word_i[i][7];
            end
            if (bus.eop_i) begin
              state <= S_TRAIL;
              cnt   <= CNT_W'(TRAIL_LOAD);
            end
          end else begin
            // Starved mid-packet: close the burst on the word already sent.
            underflow_q <= 1'b1;
            byte_data_q <= trailer;
            valid_q     <= '1;
            if (TRAIL_CYCLES > 1) begin
              state <= S_TRAIL;
              cnt   <= CNT_W'(UF_LOAD);
            end else begin
              state <= S_EXIT;
            end
          end
        end
        S_TRAIL: begin
          byte_data_q <= trailer;
          valid_q     <= '1;
          if (cnt == '0) state <= S_EXIT;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_EXIT: begin
          byte_data_q <= '0;
          valid_q     <= '0;
          hs_req_q    <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o     = (state == S_DATA);
  assign bus.hs_req_o    = hs_req_q;
  assign bus.byte_data_o = byte_data_q;
  assign bus.valid_o     = valid_q;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_dphy_lane_tx.sv
// Directed bench for dphy_lane_tx: 4-lane default instance plus a 2-lane PREP=1/TRAIL=3 instance.
module tb_dphy_lane_tx;
  localparam int unsigned LA = 4, PA = 2, TA = 2;
  localparam int unsigned LB = 2, PB = 1, TB = 3;

  logic byte_clk_i = 1'b0;
  logic rst_n_i    = 1'b1;
  always #5 byte_clk_i = ~byte_clk_i;

  dphy_lane_tx_if #(.DATA_LANES(LA)) a_bus ();
  dphy_lane_tx_if #(.DATA_LANES(LB)) b_bus ();

  dphy_lane_tx #(.DATA_LANES(LA), .SYNC_BYTE(8'hB8), .PREP_CYCLES(PA), .TRAIL_CYCLES(TA)) u_a (
    .byte_clk_i(byte_clk_i), .rst_n_i(rst_n_i), .bus(a_bus.slave));
  dphy_lane_tx #(.DATA_LANES(LB), .SYNC_BYTE(8'hB8), .PREP_CYCLES(PB), .TRAIL_CYCLES(TB)) u_b (
    .byte_clk_i(byte_clk_i), .rst_n_i(rst_n_i), .bus(b_bus.slave));

  int tests  = 0;
  int errors = 0;

  logic [35:0] log_a[$];
  logic [35:0] log_b[$];
  logic [35:0] exp_q[$];
  int   uf_a = 0, stray = 0, rises_a = 0, gap_a = 0, low_a = 0;
  logic hs_prev_a = 1'b0;

  // Wire log: one entry per cycle while hs_req_o is high, sampled mid-cycle.
  always @(negedge byte_clk_i) begin
    if (a_bus.hs_req_o) begin
      log_a.push_back(36'({a_bus.valid_o, a_bus.byte_data_o}));
      if (!hs_prev_a) begin rises_a++; gap_a = low_a; end
      low_a = 0;
    end else begin
      low_a++;
      if (a_bus.valid_o != '0) stray++;
    end
    hs_prev_a = a_bus.hs_req_o;
    if (a_bus.underflow_o) uf_a++;
    if (b_bus.hs_req_o) log_b.push_back(36'({b_bus.valid_o, b_bus.byte_data_o}));
    else if (b_bus.valid_o != '0) stray++;
  end

  task automatic set_in(input int sel, input logic [31:0] w, input logic v, input logic e);
    if (sel == 0) begin a_bus.word_i = w;        a_bus.valid_i = v; a_bus.eop_i = e; end
    else          begin b_bus.word_i = w[15:0];  b_bus.valid_i = v; b_bus.eop_i = e; end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_bus.ready_o : b_bus.ready_o;
  endfunction

  function automatic logic hs(input int sel);
    return (sel == 0) ? a_bus.hs_req_o : b_bus.hs_req_o;
  endfunction

  // Present words with valid held; advance only on valid & ready.
  task automatic feed(input int sel, input logic [31:0] ws[$], input bit eop_last, output int lat);
    int   idx = 0;
    int   cyc = 0;
    logic r;
    lat = -1;
    while (idx < ws.size() && cyc < 100) begin
      @(negedge byte_clk_i);
      set_in(sel, ws[idx], 1'b1, eop_last && (idx == ws.size() - 1));
      r = rdy(sel);
      @(posedge byte_clk_i); #1;
      cyc++;
      if (lat < 0 && hs(sel)) lat = cyc;
      if (r) idx++;
    end
    tests++;
    if (idx != ws.size()) begin
      errors++;
      $display("FAIL feed_timeout sel=%0d accepted=%0d required=%0d", sel, idx, ws.size());
    end
  endtask

  task automatic wait_idle(input int sel);
    int cyc = 0;
    @(negedge byte_clk_i);
    set_in(sel, 32'h0, 1'b0, 1'b0);
    while (hs(sel) && cyc < 50) begin @(negedge byte_clk_i); cyc++; end
    tests++;
    if (hs(sel)) begin errors++; $display("FAIL burst_end_timeout sel=%0d hs_req=1 required=0", sel); end
  endtask

  // Expected wire image of one burst: PREP idle, sync, payload, trailer.
  function automatic void add_burst(input int lanes, input int p, input int t, input logic [31:0] ws[$]);
    logic [35:0] vm;
    logic [31:0] dm, tr, last;
    vm   = 36'((1 << lanes) - 1) << (8 * lanes);
    dm   = (lanes == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * lanes)) - 1);
    last = (ws.size() > 0) ? ws[ws.size() - 1] : 32'hB8B8_B8B8;
    tr   = '0;
    for (int i = 0; i < lanes; i++) tr[8*i +: 8] = last[8*i+7] ? 8'h00 : 8'hFF;
    for (int i = 0; i < p; i++) exp_q.push_back(36'h0);
    exp_q.push_back(vm | 36'(32'hB8B8_B8B8 & dm));
    foreach (ws[i]) exp_q.push_back(vm | 36'(ws[i] & dm));
    for (int i = 0; i < t; i++) exp_q.push_back(vm | 36'(tr));
  endfunction

  task automatic test_reset();
    set_in(0, 32'h0, 1'b0, 1'b0);
    set_in(1, 32'h0, 1'b0, 1'b0);
    #1 rst_n_i = 1'b0;
    repeat (3) @(negedge byte_clk_i);
    tests++;
    if ({a_bus.hs_req_o, a_bus.ready_o, a_bus.underflow_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000", {a_bus.hs_req_o, a_bus.ready_o, a_bus.underflow_o});
    end
    tests++;
    if ({a_bus.valid_o, a_bus.byte_data_o} !== 36'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {a_bus.valid_o, a_bus.byte_data_o});
    end
    rst_n_i = 1'b1;
    repeat (3) @(negedge byte_clk_i);
    tests++;
    if ({a_bus.hs_req_o, a_bus.ready_o, b_bus.hs_req_o} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=000", {a_bus.hs_req_o, a_bus.ready_o, b_bus.hs_req_o});
    end
  endtask

  task automatic test_packet();
    logic [31:0] ws[$] = '{32'h0302_0100, 32'h0706_0504, 32'h8B8A_8988};
    int lat, n0;
    exp_q.delete();
    n0 = log_a.size();
    feed(0, ws, 1'b1, lat);
    wait_idle(0);
    tests++;
    if (lat !== 1) begin errors++; $display("FAIL t1_hs_latency got=%0d exp=1", lat); end
    add_burst(LA, PA, TA, ws);
    tests++;
    if (log_a.size() - n0 != 8) begin errors++; $display("FAIL t1_len got=%0d exp=8", log_a.size() - n0); end
    for (int i = 0; i < exp_q.size(); i++) if (n0 + i < log_a.size()) begin
      tests++;
      if (log_a[n0+i] !== exp_q[i]) begin errors++; $display("FAIL t1_beat%0d got=%h exp=%h", i, log_a[n0+i], exp_q[i]); end
    end
    tests++;
    if (log_a[log_a.size()-1] !== 36'hF_0000_0000) begin
      errors++; $display("FAIL t1_trailer got=%h exp=F00000000", log_a[log_a.size()-1]);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] ws[$] = '{32'h7F7F_7F7F};
    int lat, n0;
    exp_q.delete();
    n0 = log_a.size();
    feed(0, ws, 1'b1, lat);
    wait_idle(0);
    add_burst(LA, PA, TA, ws);
    tests++;
    if (log_a.size() - n0 != exp_q.size()) begin errors++; $display("FAIL t2_len got=%0d exp=%0d", log_a.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (n0 + i < log_a.size()) begin
      tests++;
      if (log_a[n0+i] !== exp_q[i]) begin errors++; $display("FAIL t2_beat%0d got=%h exp=%h", i, log_a[n0+i], exp_q[i]); end
    end
    tests++;
    if (log_a[n0+4] !== 36'hF_FFFF_FFFF) begin errors++; $display("FAIL t2_trailer got=%h exp=FFFFFFFFF", log_a[n0+4]); end
  endtask

  task automatic test_underflow();
    logic [31:0] first[$] = '{32'h1122_3344, 32'h8000_FF7F};
    logic [31:0] rest[$]  = '{32'h0A0B_0C0D, 32'h0102_0304, 32'h8899_AABB};
    int lat, n0, uf0;
    exp_q.delete();
    n0  = log_a.size();
    uf0 = uf_a;
    feed(0, first, 1'b0, lat);
    @(negedge byte_clk_i);
    set_in(0, rest[0], 1'b0, 1'b1);
    @(posedge byte_clk_i); #1;
    tests++;
    if ({a_bus.underflow_o, a_bus.ready_o} !== 2'b10) begin
      errors++; $display("FAIL t3_uf_ready got=%b exp=10", {a_bus.underflow_o, a_bus.ready_o});
    end
    wait_idle(0);
    feed(0, rest, 1'b1, lat);
    wait_idle(0);
    tests++;
    if (uf_a - uf0 !== 1) begin errors++; $display("FAIL t3_uf_pulses got=%0d exp=1", uf_a - uf0); end
    tests++;
    if (log_a[n0+5] !== 36'hF_00FF_00FF) begin errors++; $display("FAIL t3_trailer got=%h exp=F00FF00FF", log_a[n0+5]); end
    add_burst(LA, PA, TA, first);
    add_burst(LA, PA, TA, rest);
    tests++;
    if (log_a.size() - n0 != exp_q.size()) begin errors++; $display("FAIL t3_len got=%0d exp=%0d", log_a.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (n0 + i < log_a.size()) begin
      tests++;
      if (log_a[n0+i] !== exp_q[i]) begin errors++; $display("FAIL t3_beat%0d got=%h exp=%h", i, log_a[n0+i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa[$] = '{32'hA0A1_A2A3, 32'h2425_2627};
    logic [31:0] wb[$] = '{32'h5A5B_5C5D};
    int lat, n0, r0;
    exp_q.delete();
    n0 = log_a.size();
    r0 = rises_a;
    feed(0, wa, 1'b1, lat);
    feed(0, wb, 1'b1, lat);
    wait_idle(0);
    tests++;
    if (rises_a - r0 !== 2) begin errors++; $display("FAIL t4_bursts got=%0d exp=2", rises_a - r0); end
    tests++;
    if (gap_a !== 1) begin errors++; $display("FAIL t4_gap got=%0d exp=1", gap_a); end
    add_burst(LA, PA, TA, wa);
    add_burst(LA, PA, TA, wb);
    tests++;
    if (log_a.size() - n0 != exp_q.size()) begin errors++; $display("FAIL t4_len got=%0d exp=%0d", log_a.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (n0 + i < log_a.size()) begin
      tests++;
      if (log_a[n0+i] !== exp_q[i]) begin errors++; $display("FAIL t4_beat%0d got=%h exp=%h", i, log_a[n0+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] ws[$] = '{32'h0101_0101, 32'h0202_0202, 32'h8383_0303};
    logic [31:0] part[$];
    int lat, n0;
    part = '{ws[0], ws[1]};
    feed(0, part, 1'b0, lat);
    #2 rst_n_i = 1'b0;
    #1;
    tests++;
    if ({a_bus.hs_req_o, a_bus.ready_o, a_bus.valid_o, a_bus.byte_data_o} !== 38'h0) begin
      errors++; $display("FAIL t5_async_reset got=%h exp=0", {a_bus.hs_req_o, a_bus.ready_o, a_bus.valid_o, a_bus.byte_data_o});
    end
    set_in(0, 32'h0, 1'b0, 1'b0);
    @(negedge byte_clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge byte_clk_i);
    exp_q.delete();
    n0 = log_a.size();
    feed(0, ws, 1'b1, lat);
    wait_idle(0);
    add_burst(LA, PA, TA, ws);
    tests++;
    if (log_a.size() - n0 != exp_q.size()) begin errors++; $display("FAIL t5_len got=%0d exp=%0d", log_a.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (n0 + i < log_a.size()) begin
      tests++;
      if (log_a[n0+i] !== exp_q[i]) begin errors++; $display("FAIL t5_beat%0d got=%h exp=%h", i, log_a[n0+i], exp_q[i]); end
    end
  endtask

  task automatic test_two_lane();
    logic [31:0] ws[$] = '{32'h0000_0100, 32'h0000_8302, 32'h0000_8504};
    int lat, n0, k;
    exp_q.delete();
    n0 = log_b.size();
    feed(1, ws, 1'b1, lat);
    wait_idle(1);
    tests++;
    if (log_b.size() - n0 != 8) begin errors++; $display("FAIL t6_burst_len got=%0d exp=8", log_b.size() - n0); end
    add_burst(LB, PB, TB, ws);
    for (int i = 0; i < exp_q.size(); i++) if (n0 + i < log_b.size()) begin
      tests++;
      if (log_b[n0+i] !== exp_q[i]) begin errors++; $display("FAIL t6_beat%0d got=%h exp=%h", i, log_b[n0+i], exp_q[i]); end
    end
    // Receive-side view: lock on the first all-lane sync byte, then words follow.
    k = -1;
    for (int i = n0; i < log_b.size(); i++)
      if (k < 0 && log_b[i][17:16] == 2'b11 && log_b[i][15:0] == 16'hB8B8) k = i - n0;
    tests++;
    if (k !== 1) begin errors++; $display("FAIL t6_sync_pos got=%0d exp=1", k); end
    if (k >= 0) for (int j = 0; j < 3; j++) if (n0 + k + 1 + j < log_b.size()) begin
      tests++;
      if (log_b[n0+k+1+j][15:0] !== ws[j][15:0]) begin
        errors++; $display("FAIL t6_rx_word%0d got=%h exp=%h", j, log_b[n0+k+1+j][15:0], ws[j][15:0]);
      end
    end
    tests++;
    if (log_b[log_b.size()-1] !== 36'h3_00FF) begin errors++; $display("FAIL t6_trailer got=%h exp=3_00FF", log_b[log_b.size()-1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_packet();
    test_single_word();
    test_underflow();
    test_back_to_back();
    test_reset_mid_data();
    test_two_lane();
    tests++;
    if (stray !== 0) begin errors++; $display("FAIL valid_without_hs got=%0d exp=0", stray); end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
